// File: rtl/fdiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fdiv_seq_pkg
// Purpose : Shared FPU number-format constants, FSM state encoding and
//           operand classification helpers for the iterative divider.
// Rev     : 1.0  initial release
// ============================================================================
package fdiv_seq_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [EXP_W-1:0] EXP_ONES = 8'hFF;
  localparam logic [EXP_W-1:0] EXP_ZERO = 8'h00;

  // Total quotient bits developed: hidden bit + 23 fraction + guard + one
  // spare so that a quotient below 1.0 still yields a full mantissa.
  localparam int QBITS = 26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [EXP_W-1:0] exp_of(input logic [31:0] x);
    return x[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] man_of(input logic [31:0] x);
    return x[22:0];
  endfunction

  // Infinity/NaN encoding (exponent all ones)
  function automatic logic exp_is_max(input logic [31:0] x);
    return x[30:23] == EXP_ONES;
  endfunction

  // Zero or denormal (flushed to zero)
  function automatic logic exp_is_zero(input logic [31:0] x);
    return x[30:23] == EXP_ZERO;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fdiv_step.sv
`default_nettype none
// ============================================================================
// Module  : fdiv_step
// Purpose : One restoring-division step: compare, conditional subtract,
//           shift remainder and append one quotient bit.
// Rev     : 1.0  initial release
// ============================================================================
module fdiv_step (
  input  logic [25:0] r_in,
  input  logic [25:0] q_in,
  input  logic [23:0] d,
  output logic [25:0] r_out,
  output logic [25:0] q_out
);

  logic        ge;
  logic [25:0] r_sub;

  // Remainder stays below 2*d, so the shifted result always fits 26 bits
  always_comb begin
    ge    = (r_in >= {2'b00, d});
    r_sub = ge ? (r_in - {2'b00, d}) : r_in;
    r_out = r_sub << 1;
    q_out = (q_in << 1) | {25'd0, ge};
  end

endmodule
`default_nettype wire

// File: rtl/fdiv_seq.sv
`default_nettype none
// ============================================================================
// Module  : fdiv_seq
// Purpose : Iterative single-precision divider y = x1 / x2 with valid/ready
//           handshakes. Denormals flush to zero, round-half-up on one guard
//           bit, specials resolved at latch time with fixed latency.
// Rev     : 1.0  initial release
// ============================================================================
module fdiv_seq
  import fdiv_seq_pkg::*;
#(
  parameter int BPC = 1  // quotient bits per CALC cycle: 1 or 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        dz
);

  localparam int         N_CYC    = QBITS / BPC;
  localparam logic [4:0] LAST_CNT = 5'(N_CYC - 1);

  state_t state, state_nx;

  logic               sign;
  logic signed [9:0]  ediff;
  logic [25:0]        rem;
  logic [23:0]        dvs;
  logic [25:0]        quo;
  logic [4:0]         cnt;
  logic               spec;
  logic [31:0]        spec_y;
  logic               spec_dz;

  // Step chain: BPC quotient bits resolved per clock
  logic [25:0] rem_ch [0:BPC];
  logic [25:0] quo_ch [0:BPC];

  assign rem_ch[0] = rem;
  assign quo_ch[0] = quo;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    fdiv_step u_step (
      .r_in  (rem_ch[i]),
      .q_in  (quo_ch[i]),
      .d     (dvs),
      .r_out (rem_ch[i+1]),
      .q_out (quo_ch[i+1])
    );
  end

  // Latch-time classification of the incoming operands
  logic              in_sign;
  logic              lat_spec;
  logic              lat_dz;
  logic [31:0]       lat_y;
  logic signed [9:0] lat_ediff;

  always_comb begin
    in_sign   = x1[31] ^ x2[31];
    lat_ediff = $signed({2'b00, exp_of(x1)}) - $signed({2'b00, exp_of(x2)})
                + 10'(BIAS);
    lat_spec  = 1'b1;
    lat_dz    = 1'b0;
    lat_y     = {in_sign, 31'd0};
    if (exp_is_max(x1)) begin
      lat_y = {in_sign, EXP_ONES, man_of(x1)};
    end else if (exp_is_max(x2)) begin
      lat_y = {in_sign, 31'd0};
    end else if (exp_is_zero(x1)) begin
      lat_y = {in_sign, 31'd0};
    end else if (exp_is_zero(x2)) begin
      lat_y  = {in_sign, EXP_ONES, 23'd0};
      lat_dz = 1'b1;
    end else begin
      lat_spec = 1'b0;
    end
  end

  // Normalise, round and range-check the finished quotient
  logic [23:0]        nm;
  logic               ng;
  logic signed [10:0] ne;
  logic [24:0]        rnd;
  logic signed [10:0] ef;
  logic [31:0]        norm_y;
  logic               norm_ovf;
  logic               unused_hidden;

  always_comb begin
    if (quo[25]) begin
      nm = quo[25:2];
      ng = quo[1];
      ne = {ediff[9], ediff};
    end else begin
      nm = quo[24:1];
      ng = quo[0];
      ne = {ediff[9], ediff} - 11'sd1;
    end
    // A carry out leaves the fraction field at zero, i.e. mantissa 1.0
    rnd = {1'b0, nm} + {24'd0, ng};
    ef  = ne + $signed({10'd0, rnd[24]});
    if (ef >= 11'sd255) begin
      norm_y   = {sign, EXP_ONES, 23'd0};
      norm_ovf = 1'b1;
    end else if (ef <= 11'sd0) begin
      norm_y   = {sign, EXP_ZERO, 23'd0};
      norm_ovf = 1'b1;
    end else begin
      norm_y   = {sign, ef[7:0], rnd[22:0]};
      norm_ovf = 1'b0;
    end
  end

  assign unused_hidden = rnd[23];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid)          state_nx = ST_CALC;
      ST_CALC: if (cnt == LAST_CNT)   state_nx = ST_NORM;
      ST_NORM:                        state_nx = ST_DONE;
      ST_DONE: if (out_ready)         state_nx = ST_IDLE;
      default:                        state_nx = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Datapath: operand latch, iteration, result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      sign    <= 1'b0;
      ediff   <= '0;
      rem     <= '0;
      dvs     <= '0;
      quo     <= '0;
      cnt     <= '0;
      spec    <= 1'b0;
      spec_y  <= '0;
      spec_dz <= 1'b0;
      y       <= '0;
      ovf     <= 1'b0;
      dz      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          sign    <= in_sign;
          ediff   <= lat_ediff;
          rem     <= {2'b01, man_of(x1)};
          dvs     <= {1'b1, man_of(x2)};
          quo     <= '0;
          cnt     <= '0;
          spec    <= lat_spec;
          spec_y  <= lat_y;
          spec_dz <= lat_dz;
        end
        ST_CALC: begin
          rem <= rem_ch[BPC];
          quo <= quo_ch[BPC];
          cnt <= cnt + 5'd1;
        end
        ST_NORM: begin
          if (spec) begin
            y   <= spec_y;
            ovf <= 1'b0;
            dz  <= spec_dz;
          end else begin
            y   <= norm_y;
            ovf <= norm_ovf;
            dz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
